// File: rtl/sigmoid_result_checker.sv
// In-order scoreboard for sigmoid_pipelined: FIFO of expected results, one
// registered compare stage, saturating pass/fail counters and first-fail capture.
module sigmoid_result_checker #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32,
  parameter int TOL    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exp_valid,
  input  logic [DATA_W-1:0] exp_in,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_data,
  input  logic              clear,
  output logic [CNT_W-1:0]  tests_ran,
  output logic [CNT_W-1:0]  tests_failed,
  output logic              mismatch,
  output logic              first_fail_valid,
  output logic [DATA_W-1:0] first_fail_in,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [DATA_W-1:0] first_fail_got,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic [$clog2(DEPTH):0] pending,
  output logic              idle
);
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int STAGES = 1;

  typedef struct packed {
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dexp;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     cnt;
  logic              full, empty, push, pop;
  logic [STAGES:0]   vld_pipe;
  entry_t            s1_ent;
  logic [DATA_W-1:0] s1_got, diff;
  logic              fail;

  assign full      = (cnt == PW'(DEPTH));
  assign empty     = (cnt == '0);
  assign push      = exp_valid & ~full & ~clear;
  assign pop       = dut_valid & ~empty & ~clear;
  assign exp_ready = ~full;
  assign idle      = empty;
  assign pending   = cnt;

  // FIFO storage needs no reset; occupancy qualifies every read.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{din: exp_in, dexp: exp_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Compare stage: head and received beat are registered, judged next cycle.
  assign vld_pipe[0] = pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      s1_ent             <= '0;
      s1_got             <= '0;
    end else begin
      vld_pipe[STAGES:1] <= clear ? '0 : vld_pipe[STAGES-1:0];
      if (pop) begin
        s1_ent <= mem[rd_ptr];
        s1_got <= dut_data;
      end
    end
  end

  assign diff = (s1_got >= s1_ent.dexp) ? s1_got - s1_ent.dexp : s1_ent.dexp - s1_got;
  assign fail = vld_pipe[STAGES] & (diff > DATA_W'(TOL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tests_ran        <= '0;
      tests_failed     <= '0;
      mismatch         <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_in    <= '0;
      first_fail_exp   <= '0;
      first_fail_got   <= '0;
      overflow_err     <= 1'b0;
      underflow_err    <= 1'b0;
    end else if (clear) begin
      tests_ran        <= '0;
      tests_failed     <= '0;
      mismatch         <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_in    <= '0;
      first_fail_exp   <= '0;
      first_fail_got   <= '0;
      overflow_err     <= 1'b0;
      underflow_err    <= 1'b0;
    end else begin
      mismatch <= fail;
      if (vld_pipe[STAGES] && tests_ran != '1) tests_ran <= tests_ran + 1'b1;
      if (fail && tests_failed != '1)          tests_failed <= tests_failed + 1'b1;
      if (fail && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_in    <= s1_ent.din;
        first_fail_exp   <= s1_ent.dexp;
        first_fail_got   <= s1_got;
      end
      if (exp_valid && full) overflow_err  <= 1'b1;
      if (dut_valid && empty) underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sigmoid_result_checker.sv
// Directed bench for sigmoid_result_checker; a TOL=1 twin shares the stimulus.
module tb_sigmoid_result_checker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        exp_valid, dut_valid, clear;
  logic [15:0] exp_in, exp_data, dut_data;
  logic        exp_ready, mismatch, first_fail_valid, overflow_err, underflow_err, idle;
  logic [31:0] tests_ran, tests_failed;
  logic [15:0] first_fail_in, first_fail_exp, first_fail_got;
  logic [3:0]  pending;
  logic        t1_exp_ready, t1_mismatch, t1_ffv, t1_ovf, t1_unf, t1_idle;
  logic [31:0] t1_ran, t1_failed;
  logic [15:0] t1_ff_in, t1_ff_exp, t1_ff_got;
  logic [3:0]  t1_pending;

  int n_chk = 0, n_fail = 0, mm_cnt = 0, max_pend;

  always #5 clk = ~clk;

  sigmoid_result_checker #(.DATA_W(16), .DEPTH(8), .CNT_W(32), .TOL(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .exp_valid(exp_valid), .exp_in(exp_in), .exp_data(exp_data),
    .exp_ready(exp_ready), .dut_valid(dut_valid), .dut_data(dut_data), .clear(clear),
    .tests_ran(tests_ran), .tests_failed(tests_failed), .mismatch(mismatch),
    .first_fail_valid(first_fail_valid), .first_fail_in(first_fail_in),
    .first_fail_exp(first_fail_exp), .first_fail_got(first_fail_got),
    .overflow_err(overflow_err), .underflow_err(underflow_err), .pending(pending), .idle(idle));

  sigmoid_result_checker #(.DATA_W(16), .DEPTH(8), .CNT_W(32), .TOL(1)) u_tol1 (
    .clk(clk), .rst_n(rst_n), .exp_valid(exp_valid), .exp_in(exp_in), .exp_data(exp_data),
    .exp_ready(t1_exp_ready), .dut_valid(dut_valid), .dut_data(dut_data), .clear(clear),
    .tests_ran(t1_ran), .tests_failed(t1_failed), .mismatch(t1_mismatch),
    .first_fail_valid(t1_ffv), .first_fail_in(t1_ff_in),
    .first_fail_exp(t1_ff_exp), .first_fail_got(t1_ff_got),
    .overflow_err(t1_ovf), .underflow_err(t1_unf), .pending(t1_pending), .idle(t1_idle));

  always @(negedge clk) if (mismatch) mm_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    exp_valid = 1'b0; dut_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    idle_in(); clear = 1'b1; step(); clear = 1'b0;
  endtask

  function automatic logic [15:0] f(input int c);
    return 16'((c * 37 + 11) & 16'hFFFF);
  endfunction

  initial begin
    int mm0;
    rst_n = 1'b0; exp_in = '0; exp_data = '0; dut_data = '0;
    idle_in();
    #12;
    check("rst_exp_ready", exp_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_tests_ran", tests_ran, 0);
    check("rst_pending", pending, 0);
    check("rst_ff_valid", first_fail_valid, 0);
    check("rst_errs", {overflow_err, underflow_err, mismatch}, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // basic pass
    mm0 = mm_cnt;
    exp_valid = 1; exp_in = 16'h0000; exp_data = 16'h0800; step(); exp_valid = 0;
    check("basic_pending", pending, 1);
    dut_valid = 1; dut_data = 16'h0800; step(); dut_valid = 0;
    step(); step();
    check("basic_ran", tests_ran, 1);
    check("basic_failed", tests_failed, 0);
    check("basic_idle", idle, 1);
    check("basic_no_mm", mm_cnt - mm0, 0);

    // mismatch and first-fail capture
    mm0 = mm_cnt;
    exp_valid = 1; exp_in = 16'h1000; exp_data = 16'h0BA0; step();
    exp_in = 16'h2000; exp_data = 16'h0E1C; step(); exp_valid = 0;
    dut_valid = 1; dut_data = 16'h0BA0; step();
    dut_data = 16'h0E1D; step(); dut_valid = 0;
    step(); step();
    check("mm_ran", tests_ran, 3);
    check("mm_failed", tests_failed, 1);
    check("mm_pulses", mm_cnt - mm0, 1);
    check("mm_ff_valid", first_fail_valid, 1);
    check("mm_ff_in", first_fail_in, 16'h2000);
    check("mm_ff_exp", first_fail_exp, 16'h0E1C);
    check("mm_ff_got", first_fail_got, 16'h0E1D);
    check("tol1_failed", t1_failed, 0);
    check("tol1_ran", t1_ran, 3);
    do_clear();

    // full and overflow
    exp_valid = 1;
    for (int i = 0; i < 8; i++) begin
      exp_in = 16'(16'h0100 + i); exp_data = 16'(i); step();
    end
    check("full_ready", exp_ready, 0);
    check("full_pending", pending, 8);
    exp_in = 16'hDEAD; exp_data = 16'hBEEF; dut_valid = 1; dut_data = 16'h0000; step();
    exp_valid = 0;
    check("ovf_err", overflow_err, 1);
    check("ovf_pending", pending, 7);
    for (int i = 1; i < 8; i++) begin
      dut_data = 16'(i); step();
    end
    dut_valid = 0; step(); step();
    check("ovf_ran", tests_ran, 8);
    check("ovf_failed", tests_failed, 0);
    check("ovf_idle", idle, 1);
    check("ovf_no_unf", underflow_err, 0);
    do_clear();

    // underflow with same-cycle push
    exp_valid = 1; exp_in = 16'h0055; exp_data = 16'h0055;
    dut_valid = 1; dut_data = 16'h0055; step(); idle_in(); step();
    check("unf_err", underflow_err, 1);
    check("unf_ran", tests_ran, 0);
    check("unf_pending", pending, 1);
    do_clear();

    // streaming: 1000 samples, dut beat 5 cycles behind push, bad value at 700
    max_pend = 0;
    for (int c = 0; c < 1005; c++) begin
      exp_valid = (c < 1000);
      exp_in    = 16'(c);
      exp_data  = f(c);
      dut_valid = (c >= 5);
      dut_data  = f(c - 5) ^ ((c - 5 == 700) ? 16'h0001 : 16'h0000);
      step();
      if (int'(pending) > max_pend) max_pend = int'(pending);
    end
    idle_in(); step(); step();
    check("stream_pend_le6", (max_pend <= 6) ? 1 : 0, 1);
    check("stream_ran", tests_ran, 1000);
    check("stream_failed", tests_failed, 1);
    check("stream_ff_in", first_fail_in, 700);
    check("stream_ff_exp", first_fail_exp, f(700));
    check("stream_ff_got", first_fail_got, f(700) ^ 16'h0001);
    check("stream_errs", {overflow_err, underflow_err}, 0);

    // clear with 3 pending and a same-cycle beat
    exp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      exp_in = 16'(i); exp_data = 16'(i); step();
    end
    exp_valid = 0; dut_valid = 1; dut_data = 16'h1234; clear = 1; step();
    idle_in(); step(); step();
    check("clr_ran", tests_ran, 0);
    check("clr_failed", tests_failed, 0);
    check("clr_pending", pending, 0);
    check("clr_ready_idle", {exp_ready, idle}, 2'b11);
    check("clr_ff", {first_fail_valid, first_fail_in, first_fail_exp, first_fail_got}, 0);
    check("clr_flags", {mismatch, overflow_err, underflow_err}, 0);

    // asynchronous reset mid-stream
    exp_valid = 1; exp_in = 16'h0001; exp_data = 16'h0010; step();
    exp_data = 16'h0020; dut_valid = 1; dut_data = 16'h0011; step();
    step(); idle_in();
    #2 rst_n = 1'b0;
    #1;
    check("arst_ran", tests_ran, 0);
    check("arst_pending", pending, 0);
    check("arst_ready_idle", {exp_ready, idle}, 2'b11);
    check("arst_ff", {first_fail_valid, first_fail_got, mismatch}, 0);
    check("arst_errs", {overflow_err, underflow_err}, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
